// File: rtl/test_stim_port.sv
// ---------------------------------------------------------------------------
// test_stim_port
//
// Memory-mapped stimulus source for CPU self-test programs. It sits on the
// data-memory bus next to the result checker and answers CPU loads with a
// deterministic word sequence, plus a control/status word.
//
// The CPU arms the stream by writing BEGIN_SYM to the control port. Each read
// burst on the data port then returns the current word. When the burst ends,
// the block advances to the next word (SEED, SEED+STEP, ...). After NUM_WORDS
// words the block parks in DONE and returns END_SYM. Extra bursts in DONE are
// counted in overrun. Writing END_SYM while streaming aborts to DONE.
//
// A D-cache stall keeps ren high for several cycles on one access. The stream
// therefore advances once per burst (when ren falls), not once per cycle.
//
// Ports:
//   clk      in   1   clock, all state updates on the rising edge
//   rst      in   1   synchronous active-high reset
//   addr     in  30   CPU data word address
//   ren      in   1   CPU read enable, held high for a stalled access
//   wen      in   1   CPU write enable
//   wdata    in  32   CPU write data, little-endian byte order
//   rdata    out 32   read data, little-endian byte order
//   hit      out  1   read addressed to the data or control port
//   idx      out  8   number of words consumed
//   done     out  1   high in state DONE
//   overrun  out  8   data-port bursts seen in DONE, saturating at 255
// ---------------------------------------------------------------------------
module test_stim_port #(
  parameter logic [29:0] DATA_ADDR = 30'h11,
  parameter logic [29:0] CTRL_ADDR = 30'h12,
  parameter logic [31:0] BEGIN_SYM = 32'h00000168,
  parameter logic [31:0] END_SYM   = 32'hFFFFFD5D,
  parameter logic [31:0] SEED      = 32'h0000DEAD,
  parameter logic [31:0] STEP      = 32'h00001000,
  parameter int unsigned NUM_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] addr,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic [7:0]  idx,
  output logic        done,
  output logic [7:0]  overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS);

  state_t      state_reg,    state_next;
  logic [7:0]  idx_reg,      idx_next;
  logic [31:0] cur_word_reg, cur_word_next;
  logic        busy_reg,     busy_next;
  logic [7:0]  overrun_reg,  overrun_next;

  // Readable (big-endian) view of write data and of the value being returned.
  logic [31:0] wdata_rd;
  logic [31:0] rdata_rd;

  // The bus is little-endian while the symbols are defined in readable
  // order, so both directions go through the same byte reversal.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bswap
      assign wdata_rd[8*gi +: 8] = wdata[8*(3-gi) +: 8];
      assign rdata[8*gi +: 8]    = rdata_rd[8*(3-gi) +: 8];
    end
  endgenerate

  logic data_sel;
  logic ctrl_sel;
  logic ctrl_wr;
  logic begin_wr;
  logic end_wr;
  logic burst_end;

  assign data_sel  = (addr == DATA_ADDR);
  assign ctrl_sel  = (addr == CTRL_ADDR);
  assign ctrl_wr   = wen && ctrl_sel;
  assign begin_wr  = ctrl_wr && (wdata_rd == BEGIN_SYM);
  // END_SYM only has an effect while streaming.
  assign end_wr    = ctrl_wr && (wdata_rd == END_SYM) && (state_reg == ST_STREAM);
  // A burst ends on the first cycle that ren is low after a data-port read.
  assign burst_end = busy_reg && !ren;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= 8'd0;
      cur_word_reg <= SEED;
      busy_reg     <= 1'b0;
      overrun_reg  <= 8'd0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      cur_word_reg <= cur_word_next;
      busy_reg     <= busy_next;
      overrun_reg  <= overrun_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    cur_word_next = cur_word_reg;
    busy_next     = busy_reg;
    overrun_next  = overrun_reg;

    // A read of another port while ren stays high neither starts nor ends
    // a data burst.
    if (ren && data_sel) begin
      busy_next = 1'b1;
    end else if (!ren) begin
      busy_next = 1'b0;
    end

    // An effective control write takes priority over a coincident burst
    // end. The advance that burst would have caused is dropped.
    if (begin_wr) begin
      state_next    = ST_STREAM;
      idx_next      = 8'd0;
      cur_word_next = SEED;
      overrun_next  = 8'd0;
    end else if (end_wr) begin
      state_next = ST_DONE;
    end else if (burst_end) begin
      case (state_reg)
        ST_STREAM: begin
          idx_next      = idx_reg + 8'd1;
          cur_word_next = cur_word_reg + STEP;
          if ((idx_reg + 8'd1) == LAST_IDX) begin
            state_next = ST_DONE;
          end
        end
        ST_DONE: begin
          if (overrun_reg != 8'hFF) begin
            overrun_next = overrun_reg + 8'd1;
          end
        end
        default: begin
          // Bursts in IDLE are ignored.
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read path: combinational from registered state. The data value only
  // changes on a burst end or a control write, so it stays stable across
  // a stalled access.
  // -------------------------------------------------------------------------
  logic [31:0] data_val;
  logic [31:0] ctrl_val;

  always_comb begin
    data_val = 32'd0;
    case (state_reg)
      ST_STREAM: data_val = cur_word_reg;
      ST_DONE:   data_val = END_SYM;
      default:   data_val = 32'd0;
    endcase
  end

  assign ctrl_val = {22'd0, state_reg, idx_reg};

  always_comb begin
    rdata_rd = 32'd0;
    if (ren) begin
      if (data_sel) begin
        rdata_rd = data_val;
      end else if (ctrl_sel) begin
        rdata_rd = ctrl_val;
      end
    end
  end

  assign hit     = ren && (data_sel || ctrl_sel);
  assign idx     = idx_reg;
  assign done    = (state_reg == ST_DONE);
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_test_stim_port.sv
// ---------------------------------------------------------------------------
// tb_test_stim_port
//
// Self-checking bench for test_stim_port. It runs directed scenarios and then
// randomized bus operations. All results are compared against a word-level
// model: the stream word is computed as SEED + STEP*idx, and counters and
// state follow the arm/abort/burst rules directly.
// ---------------------------------------------------------------------------
module tb_test_stim_port;

  localparam logic [29:0] DATA_ADDR = 30'h11;
  localparam logic [29:0] CTRL_ADDR = 30'h12;
  localparam logic [31:0] BEGIN_SYM = 32'h00000168;
  localparam logic [31:0] END_SYM   = 32'hFFFFFD5D;
  localparam logic [31:0] SEED      = 32'h0000DEAD;
  localparam logic [31:0] STEP      = 32'h00001000;
  localparam int          NUM_WORDS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] addr;
  logic        ren;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic [7:0]  idx;
  logic        done;
  logic [7:0]  overrun;

  always #5 clk = ~clk;

  test_stim_port #(
    .DATA_ADDR (DATA_ADDR),
    .CTRL_ADDR (CTRL_ADDR),
    .BEGIN_SYM (BEGIN_SYM),
    .END_SYM   (END_SYM),
    .SEED      (SEED),
    .STEP      (STEP),
    .NUM_WORDS (NUM_WORDS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .ren     (ren),
    .wen     (wen),
    .wdata   (wdata),
    .rdata   (rdata),
    .hit     (hit),
    .idx     (idx),
    .done    (done),
    .overrun (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0 = idle, 1 = streaming, 2 = done.
  int m_state;
  int m_idx;
  int m_over;

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [31:0] exp_data();
    if (m_state == 1) return SEED + STEP * 32'(m_idx);
    if (m_state == 2) return END_SYM;
    return 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".idx"}, 32'(idx), 32'(m_idx));
    check({tag, ".done"}, 32'(done), 32'(m_state == 2));
    check({tag, ".overrun"}, 32'(overrun), 32'(m_over));
  endtask

  task automatic model_reset();
    m_state = 0;
    m_idx   = 0;
    m_over  = 0;
  endtask

  task automatic model_write(input logic [31:0] readable);
    if (readable == BEGIN_SYM) begin
      m_state = 1;
      m_idx   = 0;
      m_over  = 0;
    end else if (readable == END_SYM && m_state == 1) begin
      m_state = 2;
    end
  endtask

  task automatic model_burst_end();
    if (m_state == 1) begin
      m_idx++;
      if (m_idx == NUM_WORDS) m_state = 2;
    end else if (m_state == 2) begin
      if (m_over < 255) m_over++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ren = 1'b0;
    wen = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  // One data-port burst of len cycles. With wr_begin set, BEGIN_SYM is
  // written on the very cycle the burst ends.
  task automatic data_burst(input int len, input bit wr_begin, input bit verbose);
    logic [31:0] expv;
    expv = exp_data();
    for (int i = 0; i < len; i++) begin
      ren  = 1'b1;
      wen  = 1'b0;
      addr = DATA_ADDR;
      #1;
      check("data.rdata", rdata, bswap(expv));
      check("data.hit", 32'(hit), 32'd1);
      check("data.idx_hold", 32'(idx), 32'(m_idx));
      cyc();
    end
    ren  = 1'b0;
    addr = 30'($urandom_range(0, 31));
    if (wr_begin) begin
      wen   = 1'b1;
      addr  = CTRL_ADDR;
      wdata = bswap(BEGIN_SYM);
    end
    #1;
    check("data.hit_off", 32'(hit), 32'd0);
    cyc();
    wen = 1'b0;
    if (wr_begin) model_write(BEGIN_SYM);
    else          model_burst_end();
    check_status("burst");
    if (verbose)
      $display("burst len=%0d wr=%0d word=%08h idx=%0d done=%0d ovr=%0d",
               len, wr_begin, expv, idx, done, overrun);
  endtask

  task automatic ctrl_read();
    ren  = 1'b1;
    wen  = 1'b0;
    addr = CTRL_ADDR;
    #1;
    check("ctrl.rdata", rdata, bswap({22'd0, 2'(m_state), 8'(m_idx)}));
    check("ctrl.hit", 32'(hit), 32'd1);
    cyc();
    ren = 1'b0;
    $display("ctrl read state=%0d idx=%0d", m_state, m_idx);
  endtask

  task automatic ctrl_write(input logic [31:0] readable);
    ren   = 1'b0;
    wen   = 1'b1;
    addr  = CTRL_ADDR;
    wdata = bswap(readable);
    cyc();
    wen = 1'b0;
    model_write(readable);
    check_status("write");
    $display("ctrl write %08h -> state=%0d idx=%0d", readable, m_state, m_idx);
  endtask

  // Reset lands while a data burst is in progress; ren then falls.
  task automatic reset_in_burst();
    ren  = 1'b1;
    wen  = 1'b0;
    addr = DATA_ADDR;
    cyc();
    rst = 1'b1;
    cyc();
    model_reset();
    rst = 1'b0;
    ren = 1'b0;
    cyc();
    check_status("rst_burst");
    ctrl_read();
    $display("reset in burst -> idx=%0d done=%0d", idx, done);
  endtask

  initial begin
    rst   = 1'b1;
    addr  = '0;
    ren   = 1'b0;
    wen   = 1'b0;
    wdata = '0;
    cyc();
    cyc();
    rst = 1'b0;
    model_reset();

    // Reset state and a read before arming.
    check_status("reset");
    data_burst(1, 1'b0, 1'b1);
    ctrl_read();

    // Three single-cycle reads after arming.
    ctrl_write(BEGIN_SYM);
    for (int i = 0; i < 3; i++) begin
      data_burst(1, 1'b0, 1'b1);
      idle(1);
    end
    check("three.idx", 32'(idx), 32'd3);

    // Stalled read held for five cycles.
    ctrl_write(BEGIN_SYM);
    data_burst(5, 1'b0, 1'b1);
    check("stall.idx", 32'(idx), 32'd1);

    // Full stream, then overrun bursts.
    ctrl_write(BEGIN_SYM);
    for (int i = 0; i < NUM_WORDS; i++) data_burst(1 + (i % 3), 1'b0, 1'b1);
    check("full.done", 32'(done), 32'd1);
    data_burst(1, 1'b0, 1'b1);
    data_burst(2, 1'b0, 1'b1);
    check("full.overrun", 32'(overrun), 32'd2);

    // Restart on the cycle a burst ends, then abort.
    ctrl_write(BEGIN_SYM);
    for (int i = 0; i < 4; i++) data_burst(1, 1'b0, 1'b0);
    data_burst(2, 1'b1, 1'b1);
    check("restart.idx", 32'(idx), 32'd0);
    data_burst(1, 1'b0, 1'b1);
    ctrl_write(END_SYM);
    check("abort.done", 32'(done), 32'd1);

    // Reset in the middle of a burst at idx=2.
    ctrl_write(BEGIN_SYM);
    data_burst(1, 1'b0, 1'b0);
    data_burst(1, 1'b0, 1'b0);
    reset_in_burst();

    // Overrun saturation.
    ctrl_write(BEGIN_SYM);
    for (int i = 0; i < NUM_WORDS + 260; i++) data_burst(1, 1'b0, 1'b0);
    check("sat.overrun", 32'(overrun), 32'd255);

    // Randomized operations.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: data_burst(int'($urandom_range(1, 4)), ($urandom_range(0, 7) == 0), 1'b1);
        4: ctrl_read();
        5: ctrl_write(BEGIN_SYM);
        6: ctrl_write(END_SYM);
        7: ctrl_write($urandom);
        8: idle(int'($urandom_range(1, 3)));
        default: if ($urandom_range(0, 3) == 0) reset_in_burst();
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
